// File: rtl/hpdcache_mem_write_throttle_if.sv
// Write channel bundle between the write-buffer adapter, this throttle and
// the external memory write port.
//   req_*  : write-request (meta) channel, master -> slave
//   data_* : write-data channel (data/be/last), master -> slave
//   resp_* : write acknowledgement channel, slave -> master
interface hpdcache_mem_write_throttle_if #(
  parameter int unsigned MetaWidth = 64,
  parameter int unsigned DataWidth = 512,
  parameter int unsigned RespWidth = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [MetaWidth-1:0]   req;
  logic                   data_valid;
  logic                   data_ready;
  logic [DataWidth-1:0]   data;
  logic [DataWidth/8-1:0] be;
  logic                   last;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [RespWidth-1:0]   resp;

  modport master (
    output req_valid, input req_ready, output req,
    output data_valid, input data_ready, output data, output be, output last,
    input resp_valid, output resp_ready, input resp
  );

  modport slave (
    input req_valid, output req_ready, input req,
    input data_valid, output data_ready, input data, input be, input last,
    output resp_valid, input resp_ready, output resp
  );
endinterface

// File: rtl/hpdcache_mem_write_throttle.sv
// Memory write throttle: buffers the write-request and write-data channels
// in FIFOs, caps in-flight write requests with a credit counter, keeps each
// data beat behind its request, and passes acks straight back upstream.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   idle_o        : both FIFOs empty and nothing outstanding
//   in_io         : upstream side (slave modport)
//   mem_io        : memory side (master modport)

// Simple synchronous FIFO; full/empty come from a registered occupancy count,
// so full never lets a push through on the cycle the head pops.
module hpdcache_mem_write_throttle_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             push, pop;

  assign full_o  = (occ_q == OccW'(Depth));
  assign empty_o = (occ_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    if (push && !pop)      occ_d = occ_q + OccW'(1);
    else if (!push && pop) occ_d = occ_q - OccW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

module hpdcache_mem_write_throttle #(
  parameter int unsigned MetaWidth      = 64,
  parameter int unsigned DataWidth      = 512,
  parameter int unsigned MetaDepth      = 4,
  parameter int unsigned DataDepth      = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned RespWidth      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  output logic                                 idle_o,
  hpdcache_mem_write_throttle_if.slave         in_io,
  hpdcache_mem_write_throttle_if.master        mem_io
);
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned DEntryW = DataWidth + BeWidth + 1;

  logic               meta_full, meta_empty;
  logic               data_full, data_empty;
  logic [DEntryW-1:0] data_head;
  logic               req_hs, data_hs, last_hs, resp_hs;
  logic [CntW-1:0]    out_cnt_q, out_cnt_d;
  logic [CntW-1:0]    credit_q, credit_d;

  hpdcache_mem_write_throttle_fifo #(
    .Width (MetaWidth),
    .Depth (MetaDepth)
  ) i_meta_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_io.req_valid),
    .wdata_i (in_io.req),
    .pop_i   (req_hs),
    .full_o  (meta_full),
    .empty_o (meta_empty),
    .rdata_o (mem_io.req)
  );

  hpdcache_mem_write_throttle_fifo #(
    .Width (DEntryW),
    .Depth (DataDepth)
  ) i_data_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_io.data_valid),
    .wdata_i ({in_io.last, in_io.be, in_io.data}),
    .pop_i   (data_hs),
    .full_o  (data_full),
    .empty_o (data_empty),
    .rdata_o (data_head)
  );

  assign in_io.req_ready  = ~meta_full;
  assign in_io.data_ready = ~data_full;

  // Cap only loosens while a request waits (count can only drop), so valid
  // never falls before its handshake.
  assign mem_io.req_valid  = ~meta_empty & (out_cnt_q < CntW'(MaxOutstanding));
  // A beat may only leave once a request it belongs to has been issued.
  assign mem_io.data_valid = ~data_empty & (credit_q != '0);
  assign {mem_io.last, mem_io.be, mem_io.data} = data_head;

  // Acknowledgements are a pure pass-through.
  assign in_io.resp_valid  = mem_io.resp_valid;
  assign in_io.resp        = mem_io.resp;
  assign mem_io.resp_ready = in_io.resp_ready;

  assign req_hs  = mem_io.req_valid & mem_io.req_ready;
  assign data_hs = mem_io.data_valid & mem_io.data_ready;
  assign last_hs = data_hs & mem_io.last;
  assign resp_hs = mem_io.resp_valid & in_io.resp_ready;

  always_comb begin
    out_cnt_d = out_cnt_q;
    credit_d  = credit_q;
    if (req_hs && !resp_hs)                         out_cnt_d = out_cnt_q + CntW'(1);
    else if (!req_hs && resp_hs && out_cnt_q != '0) out_cnt_d = out_cnt_q - CntW'(1);
    if (req_hs && !last_hs)                         credit_d  = credit_q + CntW'(1);
    else if (!req_hs && last_hs)                    credit_d  = credit_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_cnt_q <= '0;
      credit_q  <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      credit_q  <= credit_d;
    end
  end

  assign idle_o = meta_empty & data_empty & (out_cnt_q == '0);

  // An ack with nothing outstanding is a protocol error upstream of us.
  a_no_spurious_ack : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(resp_hs && (out_cnt_q == '0)));
  a_credit_le_outstanding : assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_q <= out_cnt_q);
endmodule

// File: tb/tb_hpdcache_mem_write_throttle.sv
module tb_hpdcache_mem_write_throttle;
  localparam int unsigned MW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned RW = 8;

  logic clk;
  logic rst_n;
  logic idle;
  int   vectors;
  int   miscompares;

  hpdcache_mem_write_throttle_if #(.MetaWidth(MW), .DataWidth(DW), .RespWidth(RW)) in_bus ();
  hpdcache_mem_write_throttle_if #(.MetaWidth(MW), .DataWidth(DW), .RespWidth(RW)) mem_bus ();

  hpdcache_mem_write_throttle #(
    .MetaWidth      (MW),
    .DataWidth      (DW),
    .MetaDepth      (4),
    .DataDepth      (4),
    .MaxOutstanding (8),
    .RespWidth      (RW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .idle_o (idle),
    .in_io  (in_bus),
    .mem_io (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_defaults();
    in_bus.req_valid   = 1'b0;
    in_bus.req         = '0;
    in_bus.data_valid  = 1'b0;
    in_bus.data        = '0;
    in_bus.be          = '1;
    in_bus.last        = 1'b1;
    in_bus.resp_ready  = 1'b1;
    mem_bus.req_ready  = 1'b1;
    mem_bus.data_ready = 1'b1;
    mem_bus.resp_valid = 1'b0;
    mem_bus.resp       = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_defaults();
    tick();
    rst_n = 1'b1;
  endtask

  int n_req_in, n_dat_in, n_issued, n_dsent;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    set_defaults();
    tick();
    do_reset();

    // ---- reset state
    sample();
    chk1("rst_req_valid", mem_bus.req_valid, 1'b0);
    chk1("rst_data_valid", mem_bus.data_valid, 1'b0);
    chk1("rst_in_req_ready", in_bus.req_ready, 1'b1);
    chk1("rst_in_data_ready", in_bus.data_ready, 1'b1);
    chk1("rst_idle", idle, 1'b1);
    tick();

    // ---- single write: request and last data beat accepted in cycle 0
    in_bus.req_valid  = 1'b1;
    in_bus.req        = 32'hA5A5_0001;
    in_bus.data_valid = 1'b1;
    in_bus.data       = 64'hDEAD_BEEF_0123_4567;
    in_bus.be         = 8'h0F;
    in_bus.last       = 1'b1;
    sample();
    chk1("s1_c0_no_bypass", mem_bus.req_valid, 1'b0);
    tick();
    set_defaults();
    sample();
    chk1("s1_c1_req_valid", mem_bus.req_valid, 1'b1);
    chk("s1_c1_req", 64'(mem_bus.req), 64'hA5A5_0001);
    chk1("s1_c1_data_held", mem_bus.data_valid, 1'b0);
    chk1("s1_c1_idle", idle, 1'b0);
    tick();
    sample();
    chk1("s1_c2_req_valid", mem_bus.req_valid, 1'b0);
    chk1("s1_c2_data_valid", mem_bus.data_valid, 1'b1);
    chk("s1_c2_data", mem_bus.data, 64'hDEAD_BEEF_0123_4567);
    chk("s1_c2_be", 64'(mem_bus.be), 64'h0F);
    chk1("s1_c2_last", mem_bus.last, 1'b1);
    tick();
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp       = 8'h3C;
    sample();
    chk1("s1_c3_data_valid", mem_bus.data_valid, 1'b0);
    chk1("s1_c3_idle_before_ack", idle, 1'b0);
    chk1("s1_resp_valid_pass", in_bus.resp_valid, 1'b1);
    chk("s1_resp_pass", 64'(in_bus.resp), 64'h3C);
    chk1("s1_resp_ready_pass", mem_bus.resp_ready, 1'b1);
    tick();
    mem_bus.resp_valid = 1'b0;
    sample();
    chk1("s1_idle_after_ack", idle, 1'b1);
    tick();

    // ---- cap at 8 outstanding: 10 writes, no acks
    do_reset();
    n_req_in = 0; n_dat_in = 0; n_issued = 0; n_dsent = 0;
    for (int c = 0; c < 30; c++) begin
      in_bus.req_valid  = (n_req_in < 10);
      in_bus.req        = 32'(n_req_in);
      in_bus.data_valid = (n_dat_in < 10);
      in_bus.data       = 64'(n_dat_in + 100);
      sample();
      if (mem_bus.req_valid && mem_bus.req_ready) begin
        chk("s2_req_order", 64'(mem_bus.req), 64'(n_issued));
        n_issued++;
      end
      if (mem_bus.data_valid && mem_bus.data_ready) begin
        chk("s2_data_order", mem_bus.data, 64'(n_dsent + 100));
        n_dsent++;
      end
      if (in_bus.req_valid && in_bus.req_ready) n_req_in++;
      if (in_bus.data_valid && in_bus.data_ready) n_dat_in++;
      tick();
    end
    set_defaults();
    sample();
    chk("s2_req_accepted", 64'(n_req_in), 64'd10);
    chk("s2_req_issued", 64'(n_issued), 64'd8);
    chk("s2_data_sent", 64'(n_dsent), 64'd8);
    chk1("s2_capped_req_valid", mem_bus.req_valid, 1'b0);
    chk1("s2_capped_data_valid", mem_bus.data_valid, 1'b0);
    chk1("s2_meta_not_full", in_bus.req_ready, 1'b1);
    chk1("s2_idle", idle, 1'b0);
    tick();
    mem_bus.resp_valid = 1'b1;
    sample();
    chk1("s2_ack_cycle_req_valid", mem_bus.req_valid, 1'b0);
    tick();
    mem_bus.resp_valid = 1'b0;
    sample();
    chk1("s2_ninth_req_valid", mem_bus.req_valid, 1'b1);
    chk("s2_ninth_req", 64'(mem_bus.req), 64'd8);
    tick();
    sample();
    chk1("s2_ninth_data_valid", mem_bus.data_valid, 1'b1);
    chk("s2_ninth_data", mem_bus.data, 64'd108);
    chk1("s2_tenth_capped", mem_bus.req_valid, 1'b0);
    tick();

    // ---- data arrives 5 cycles ahead of its request; memory stalls request 3 cycles
    do_reset();
    mem_bus.req_ready = 1'b0;
    in_bus.data_valid = 1'b1;
    in_bus.data       = 64'h0000_0000_0000_0033;
    tick();
    in_bus.data_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      sample();
      chk1("s3_early_data_held", mem_bus.data_valid, 1'b0);
      tick();
    end
    in_bus.req_valid = 1'b1;
    in_bus.req       = 32'h33;
    sample();
    chk1("s3_c5_data_held", mem_bus.data_valid, 1'b0);
    tick();
    in_bus.req_valid = 1'b0;
    for (int c = 6; c <= 8; c++) begin
      sample();
      chk1("s3_stall_req_valid", mem_bus.req_valid, 1'b1);
      chk1("s3_stall_data_held", mem_bus.data_valid, 1'b0);
      tick();
    end
    mem_bus.req_ready = 1'b1;
    sample();
    chk1("s3_c9_req_valid", mem_bus.req_valid, 1'b1);
    chk1("s3_c9_data_held", mem_bus.data_valid, 1'b0);
    tick();
    sample();
    chk1("s3_c10_data_valid", mem_bus.data_valid, 1'b1);
    chk("s3_c10_data", mem_bus.data, 64'h33);
    tick();

    // ---- request handshake and ack in the same cycle at 3 outstanding
    do_reset();
    for (int c = 0; c < 3; c++) begin
      in_bus.req_valid  = 1'b1;
      in_bus.req        = 32'(c);
      in_bus.data_valid = 1'b1;
      in_bus.data       = 64'(c);
      tick();
    end
    in_bus.req_valid  = 1'b0;
    in_bus.data_valid = 1'b0;
    repeat (5) tick();
    sample();
    chk1("s4_three_out_idle", idle, 1'b0);
    chk1("s4_three_out_data", mem_bus.data_valid, 1'b0);
    tick();
    mem_bus.data_ready = 1'b0;
    in_bus.req_valid   = 1'b1;
    in_bus.req         = 32'h44;
    in_bus.data_valid  = 1'b1;
    in_bus.data        = 64'h44;
    tick();
    in_bus.req_valid   = 1'b0;
    in_bus.data_valid  = 1'b0;
    mem_bus.resp_valid = 1'b1;
    sample();
    chk1("s4_simul_req_valid", mem_bus.req_valid, 1'b1);
    chk1("s4_simul_resp_valid", in_bus.resp_valid, 1'b1);
    tick();
    mem_bus.resp_valid = 1'b0;
    sample();
    chk1("s4_credit_up_data_valid", mem_bus.data_valid, 1'b1);
    chk("s4_credit_up_data", mem_bus.data, 64'h44);
    tick();
    mem_bus.data_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_bus.resp_valid = 1'b1;
      sample();
      chk1("s4_drain_not_idle", idle, 1'b0);
      tick();
    end
    mem_bus.resp_valid = 1'b0;
    sample();
    chk1("s4_drained_idle", idle, 1'b1);
    tick();

    // ---- fill meta FIFO with memory stalled, then release
    do_reset();
    mem_bus.req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_bus.req_valid = 1'b1;
      in_bus.req       = 32'(c + 16);
      sample();
      chk1("s5_fill_ready", in_bus.req_ready, 1'b1);
      tick();
    end
    in_bus.req       = 32'h55;
    mem_bus.req_ready = 1'b1;
    sample();
    chk1("s5_full_ready_low", in_bus.req_ready, 1'b0);
    chk("s5_head_first", 64'(mem_bus.req), 64'd16);
    tick();
    sample();
    chk1("s5_ready_after_pop", in_bus.req_ready, 1'b1);
    chk("s5_head_second", 64'(mem_bus.req), 64'd17);
    tick();
    in_bus.req_valid = 1'b0;

    // ---- reset mid-traffic: 2 outstanding, 3 requests and 3 beats buffered
    do_reset();
    for (int c = 0; c < 2; c++) begin
      in_bus.req_valid = 1'b1;
      in_bus.req       = 32'(c);
      tick();
    end
    in_bus.req_valid = 1'b0;
    tick();
    mem_bus.req_ready  = 1'b0;
    mem_bus.data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_bus.req_valid  = 1'b1;
      in_bus.req        = 32'(c + 2);
      in_bus.data_valid = 1'b1;
      in_bus.data       = 64'(c + 2);
      tick();
    end
    in_bus.req_valid  = 1'b0;
    in_bus.data_valid = 1'b0;
    sample();
    chk1("s6_pre_req_valid", mem_bus.req_valid, 1'b1);
    chk1("s6_pre_data_valid", mem_bus.data_valid, 1'b1);
    chk1("s6_pre_idle", idle, 1'b0);
    chk1("s6_pre_req_ready", in_bus.req_ready, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sample();
    chk1("s6_post_req_valid", mem_bus.req_valid, 1'b0);
    chk1("s6_post_data_valid", mem_bus.data_valid, 1'b0);
    chk1("s6_post_idle", idle, 1'b1);
    chk1("s6_post_req_ready", in_bus.req_ready, 1'b1);
    chk1("s6_post_data_ready", in_bus.data_ready, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hpdcache_mem_write_throttle.md
Name: hpdcache_mem_write_throttle

Overview:
Sits directly downstream of the write-buffer memory-write adapter. It receives its write-request (meta) and write-data channels and feeds the cache's external memory write interface. It decouples both channels with FIFOs and caps the number of in-flight write transactions with a credit counter. It forbids a data beat from reaching memory before its request, and passes write acknowledgements back upstream.

Parameters:
MetaWidth, 64, packed width of one write-request record (addr, len, size, id, command, atomic, cacheable)
DataWidth, 512, memory write data width (bits)
MetaDepth, 4, meta FIFO entries (>=2)
DataDepth, 4, data FIFO entries (>=2)
MaxOutstanding, 8, max write requests issued and not yet acknowledged (>=1)
RespWidth, 16, packed width of one write-response record (id, error)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
idle_o  out  1  both FIFOs empty and outstanding count == 0
in_req_valid_i  in  1  upstream request valid
in_req_ready_o  out  1  meta FIFO not full
in_req_i  in  MetaWidth  upstream request record
in_data_valid_i  in  1  upstream data valid
in_data_ready_o  out  1  data FIFO not full
in_data_i  in  DataWidth  write data
in_be_i  in  DataWidth/8  byte enables
in_last_i  in  1  last beat of a transaction
mem_req_valid_o  out  1  request to memory valid
mem_req_ready_i  in  1  memory accepts request
mem_req_o  out  MetaWidth  request record
mem_data_valid_o  out  1  data to memory valid
mem_data_ready_i  in  1  memory accepts data
mem_data_o  out  DataWidth  data
mem_be_o  out  DataWidth/8  byte enables
mem_last_o  out  1  last beat
mem_resp_valid_i  in  1  write ack from memory
mem_resp_ready_o  out  1  equals out_resp_ready_i
mem_resp_i  in  RespWidth  ack record
out_resp_valid_o  out  1  equals mem_resp_valid_i
out_resp_ready_i  in  1  upstream accepts ack
out_resp_o  out  RespWidth  equals mem_resp_i

Behaviour:
- Reset (rst_ni low at a rising edge):
  - both FIFOs empty; outstanding_cnt=0; data_credit=0.
  - mem_req_valid_o=0, mem_data_valid_o=0.
  - in_req_ready_o=1, in_data_ready_o=1, idle_o=1.
  - Reset mid-transaction discards all buffered entries and counters. No response tracking survives reset.
- Upstream accept: on a valid&ready handshake, push to the respective FIFO. There is no bypass. The earliest cycle the entry appears on mem_*_valid_o is the cycle after the handshake.
- Ready signals: a full FIFO deasserts ready even if the head pops in the same cycle (registered full flag, no pop-to-push pass-through).
- Request issue: mem_req_valid_o = meta FIFO not empty AND outstanding_cnt < MaxOutstanding. mem_req_o = FIFO head. Valid is never withdrawn once raised until the handshake completes (the cap condition can only loosen while waiting).
- Data gating:
  - data_credit counts issued requests whose last data beat has not yet been sent. Width is clog2(MaxOutstanding+1).
  - mem_data_valid_o = data FIFO not empty AND data_credit > 0.
  - Data therefore leaves at the earliest one cycle after its request handshake.
- outstanding_cnt update, per cycle, with req_hs = mem_req_valid_o & mem_req_ready_i and resp_hs = mem_resp_valid_i & out_resp_ready_i:
  - +1 on req_hs only.
  - -1 on resp_hs only.
  - unchanged on both.
- data_credit update, per cycle, with last_hs = data handshake with mem_last_o=1:
  - +1 on req_hs only.
  - -1 on last_hs only.
  - unchanged on both.
- Response path is combinational pass-through, no storage.
- Spurious ack (resp_hs while outstanding_cnt==0): count stays 0; simulation assertion fires.
- Assertion: data_credit never exceeds outstanding_cnt.
- idle_o = both FIFOs empty AND outstanding_cnt==0. It is registered-state derived, with no combinational path from inputs.
- FIFO pointers wrap modulo depth. Full and empty are distinguished by an occupancy counter.

Test Plan:
- Reset then one write: req at cycle 0, data (last=1) at cycle 0 -> mem_req_valid_o=1 at cycle 1, mem_data_valid_o=1 at cycle 2 (mem readies held 1), idle_o=0 until an ack is accepted, then idle_o=1 the next cycle.
- MaxOutstanding=8, no acks, 10 requests+data -> exactly 8 req handshakes, mem_req_valid_o=0 with 2 in FIFO; one ack -> 9th request issued the cycle after.
- Data arrives 5 cycles before its request, mem_req_ready_i=0 for 3 cycles -> mem_data_valid_o stays 0 until the cycle after the request handshake.
- Request handshake and ack in the same cycle at outstanding_cnt=3 -> count remains 3; data_credit +1.
- Fill meta FIFO (MetaDepth=4, mem_req_ready_i=0) -> in_req_ready_o=0 after 4 pushes; release -> ready returns 1 the cycle after the first pop.
- rst_ni low for 1 cycle with 2 outstanding and 3 buffered entries -> next cycle all valids 0, idle_o=1, both in_*_ready_o=1.
